// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler for the register file's single write port: two FIFO'd requesters,
// round-robin drain, registered write stage. Define REGFILE_WB_FIXED_PRIO_EN for strict A priority.
module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] rf_RW,
  output logic [DATA_W-1:0] rf_WD,
  output logic              rf_RegWrite,
  output logic              rf_enable,
  output logic [NREG-1:0]   pending,
  output logic              busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

`ifndef REGFILE_WB_FIXED_PRIO_EN
  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_e;
  rr_e rr_q, rr_d;
`endif

  entry_t            a_mem_q [DEPTH];
  entry_t            a_mem_d [DEPTH];
  entry_t            b_mem_q [DEPTH];
  entry_t            b_mem_d [DEPTH];
  logic [PW-1:0]     a_wptr_q, a_wptr_d, a_rptr_q, a_rptr_d;
  logic [PW-1:0]     b_wptr_q, b_wptr_d, b_rptr_q, b_rptr_d;
  logic              a_empty_s, a_full_s, a_push_s, gnt_a_s;
  logic              b_empty_s, b_full_s, b_push_s, gnt_b_s;
  entry_t            gnt_entry_s;
  logic              out_valid_s;
  logic [ADDR_W-1:0] rf_rw_q, rf_rw_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic              rf_regwrite_q, rf_regwrite_d;
  logic              rf_enable_q;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              busy_q, busy_d;

  // Pointers carry one wrap bit above the slot index: same index + different wrap = full.
  function automatic logic fifo_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
    return (wp[IW-1:0] == rp[IW-1:0]) && (wp[IW] != rp[IW]);
  endfunction

  function automatic logic slot_valid(input int slot, input logic [PW-1:0] wp,
                                      input logic [PW-1:0] rp);
    logic [IW-1:0] off;
    off = IW'(slot) - rp[IW-1:0];
    return {1'b0, off} < (wp - rp);
  endfunction

  assign a_empty_s = (a_wptr_q == a_rptr_q);
  assign b_empty_s = (b_wptr_q == b_rptr_q);
  assign a_full_s  = fifo_full(a_wptr_q, a_rptr_q);
  assign b_full_s  = fifo_full(b_wptr_q, b_rptr_q);
  assign a_ready   = !a_full_s && !flush;
  assign b_ready   = !b_full_s && !flush;
  assign a_push_s  = a_valid && a_ready;
  assign b_push_s  = b_valid && b_ready;

  // Grant selection on the FIFO heads; flush suppresses any pop.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
`ifdef REGFILE_WB_FIXED_PRIO_EN
    if (flush) begin
      gnt_a_s = 1'b0;
    end else if (!a_empty_s) begin
      gnt_a_s = 1'b1;
    end else if (!b_empty_s) begin
      gnt_b_s = 1'b1;
    end else begin
      gnt_a_s = 1'b0;
    end
`else
    rr_d = rr_q;
    if (flush) begin
      gnt_a_s = 1'b0;
    end else if (!a_empty_s && !b_empty_s) begin
      if (rr_q == RR_A) begin
        gnt_a_s = 1'b1;
      end else begin
        gnt_b_s = 1'b1;
      end
    end else if (!a_empty_s) begin
      gnt_a_s = 1'b1;
    end else if (!b_empty_s) begin
      gnt_b_s = 1'b1;
    end else begin
      gnt_a_s = 1'b0;
    end
    if (gnt_a_s) begin
      rr_d = RR_B;
    end else if (gnt_b_s) begin
      rr_d = RR_A;
    end else begin
      rr_d = rr_q;
    end
`endif
  end

  // Requester A FIFO next state.
  always_comb begin
    a_mem_d  = a_mem_q;
    a_wptr_d = a_wptr_q;
    a_rptr_d = a_rptr_q;
    if (flush) begin
      a_wptr_d = {PW{1'b0}};
      a_rptr_d = {PW{1'b0}};
    end else begin
      if (a_push_s) begin
        a_mem_d[a_wptr_q[IW-1:0]] = '{addr: a_addr, data: a_data};
        a_wptr_d = a_wptr_q + PW'(1);
      end else begin
        a_wptr_d = a_wptr_q;
      end
      if (gnt_a_s) begin
        a_rptr_d = a_rptr_q + PW'(1);
      end else begin
        a_rptr_d = a_rptr_q;
      end
    end
  end

  // Requester B FIFO next state.
  always_comb begin
    b_mem_d  = b_mem_q;
    b_wptr_d = b_wptr_q;
    b_rptr_d = b_rptr_q;
    if (flush) begin
      b_wptr_d = {PW{1'b0}};
      b_rptr_d = {PW{1'b0}};
    end else begin
      if (b_push_s) begin
        b_mem_d[b_wptr_q[IW-1:0]] = '{addr: b_addr, data: b_data};
        b_wptr_d = b_wptr_q + PW'(1);
      end else begin
        b_wptr_d = b_wptr_q;
      end
      if (gnt_b_s) begin
        b_rptr_d = b_rptr_q + PW'(1);
      end else begin
        b_rptr_d = b_rptr_q;
      end
    end
  end

  // Output stage: the granted head is registered; R0 writes are dropped but still update RW/WD.
  always_comb begin
    if (gnt_a_s) begin
      gnt_entry_s = a_mem_q[a_rptr_q[IW-1:0]];
    end else begin
      gnt_entry_s = b_mem_q[b_rptr_q[IW-1:0]];
    end
    out_valid_s   = gnt_a_s || gnt_b_s;
    rf_rw_d       = rf_rw_q;
    rf_wd_d       = rf_wd_q;
    rf_regwrite_d = 1'b0;
    if (out_valid_s) begin
      rf_rw_d       = gnt_entry_s.addr;
      rf_wd_d       = gnt_entry_s.data;
      rf_regwrite_d = (gnt_entry_s.addr != {ADDR_W{1'b0}});
    end else begin
      rf_regwrite_d = 1'b0;
    end
  end

  // Pending/busy are built from next state so the registered copies track the queue exactly.
  always_comb begin
    pending_d = {NREG{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      pending_d[a_mem_d[i].addr] = pending_d[a_mem_d[i].addr] | slot_valid(i, a_wptr_d, a_rptr_d);
      pending_d[b_mem_d[i].addr] = pending_d[b_mem_d[i].addr] | slot_valid(i, b_wptr_d, b_rptr_d);
    end
    if (out_valid_s) begin
      pending_d[rf_rw_d] = 1'b1;
    end else begin
      pending_d[rf_rw_d] = pending_d[rf_rw_d];
    end
    pending_d[0] = 1'b0;
    busy_d = (a_wptr_d != a_rptr_d) || (b_wptr_d != b_rptr_d) || out_valid_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_mem_q[i] <= '0;
        b_mem_q[i] <= '0;
      end
      a_wptr_q      <= {PW{1'b0}};
      a_rptr_q      <= {PW{1'b0}};
      b_wptr_q      <= {PW{1'b0}};
      b_rptr_q      <= {PW{1'b0}};
`ifndef REGFILE_WB_FIXED_PRIO_EN
      rr_q          <= RR_A;
`endif
      rf_rw_q       <= {ADDR_W{1'b0}};
      rf_wd_q       <= {DATA_W{1'b0}};
      rf_regwrite_q <= 1'b0;
      rf_enable_q   <= 1'b0;
      pending_q     <= {NREG{1'b0}};
      busy_q        <= 1'b0;
    end else begin
      a_mem_q       <= a_mem_d;
      b_mem_q       <= b_mem_d;
      a_wptr_q      <= a_wptr_d;
      a_rptr_q      <= a_rptr_d;
      b_wptr_q      <= b_wptr_d;
      b_rptr_q      <= b_rptr_d;
`ifndef REGFILE_WB_FIXED_PRIO_EN
      rr_q          <= rr_d;
`endif
      rf_rw_q       <= rf_rw_d;
      rf_wd_q       <= rf_wd_d;
      rf_regwrite_q <= rf_regwrite_d;
      rf_enable_q   <= 1'b1;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
    end
  end

  assign rf_RW       = rf_rw_q;
  assign rf_WD       = rf_wd_q;
  assign rf_RegWrite = rf_regwrite_q;
  assign rf_enable   = rf_enable_q;
  assign pending     = pending_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, arbitration order, backpressure, R0 discard,
// flush and async reset. Writes are logged from rf_RegWrite at each falling edge.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [2:0]  a_addr = 3'd0, b_addr = 3'd0;
  logic [15:0] a_data = 16'd0, b_data = 16'd0;
  logic [2:0]  rf_RW;
  logic [15:0] rf_WD;
  logic        rf_RegWrite, rf_enable, busy;
  logic [7:0]  pending;

  int total = 0;
  int bad = 0;
  logic [18:0] log_q [$];

  logic [2:0]  sa_addr [8];
  logic [15:0] sa_data [8];
  logic [2:0]  sb_addr [8];
  logic [15:0] sb_data [8];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(2), .DATA_W(16), .ADDR_W(3), .NREG(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_RW(rf_RW), .rf_WD(rf_WD), .rf_RegWrite(rf_RegWrite), .rf_enable(rf_enable),
    .pending(pending), .busy(busy)
  );

  always @(negedge clk) begin
    if (rf_RegWrite === 1'b1) log_q.push_back({rf_RW, rf_WD});
  end

  task automatic drive_stream(input int na, input int nb, output int a_stall, output int b_stall);
    int ia = 0, ib = 0, cyc = 0;
    logic fa, fb;
    a_stall = 0;
    b_stall = 0;
    @(posedge clk); #1;
    while ((ia < na || ib < nb) && cyc < 40) begin
      a_valid = (ia < na);
      b_valid = (ib < nb);
      a_addr  = (ia < na) ? sa_addr[ia] : 3'd0;
      a_data  = (ia < na) ? sa_data[ia] : 16'd0;
      b_addr  = (ib < nb) ? sb_addr[ib] : 3'd0;
      b_data  = (ib < nb) ? sb_data[ib] : 16'd0;
      @(negedge clk);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      if (a_valid && !a_ready) a_stall++;
      if (b_valid && !b_ready) b_stall++;
      @(posedge clk); #1;
      if (fa) ia++;
      if (fb) ib++;
      cyc++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    total++;
    if (ia != na || ib != nb) begin
      bad++;
      $display("FAIL stream_timeout: accepted a=%0d b=%0d required a=%0d b=%0d", ia, ib, na, nb);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    total++;
    if ({rf_RW, rf_WD, rf_RegWrite, rf_enable, pending, busy} !== 29'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0", {rf_RW, rf_WD, rf_RegWrite, rf_enable, pending, busy});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (rf_enable !== 1'b0) begin
      bad++; $display("FAIL enable_before_edge: got %b required 0", rf_enable);
    end
    @(posedge clk); #1;
    total++;
    if (rf_enable !== 1'b1) begin
      bad++; $display("FAIL enable_after_edge: got %b required 1", rf_enable);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({rf_RegWrite, pending, busy, a_ready, b_ready, rf_enable} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL idle_state: got we=%b pend=%h busy=%b ar=%b br=%b en=%b required we=0 pend=00 busy=0 ar=1 br=1 en=1",
                 rf_RegWrite, pending, busy, a_ready, b_ready, rf_enable);
      end
    end
  endtask

  task automatic test_round_robin();
    int a_st, b_st;
    logic [18:0] exp_q [8];
    sa_addr = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
    sa_data = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'h0, 16'h0, 16'h0, 16'h0};
    sb_addr = '{3'd5, 3'd6, 3'd7, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    sb_data = '{16'hB005, 16'hB006, 16'hB007, 16'hB001, 16'h0, 16'h0, 16'h0, 16'h0};
`ifdef REGFILE_WB_FIXED_PRIO_EN
    exp_q = '{{3'd1, 16'hA001}, {3'd2, 16'hA002}, {3'd3, 16'hA003}, {3'd4, 16'hA004},
              {3'd5, 16'hB005}, {3'd6, 16'hB006}, {3'd7, 16'hB007}, {3'd1, 16'hB001}};
`else
    exp_q = '{{3'd1, 16'hA001}, {3'd5, 16'hB005}, {3'd2, 16'hA002}, {3'd6, 16'hB006},
              {3'd3, 16'hA003}, {3'd7, 16'hB007}, {3'd4, 16'hA004}, {3'd1, 16'hB001}};
`endif
    log_q.delete();
    drive_stream(4, 4, a_st, b_st);
    repeat (12) @(negedge clk);
    total++;
`ifdef REGFILE_WB_FIXED_PRIO_EN
    if (b_st == 0) begin
      bad++; $display("FAIL rr_backpressure: b stall cycles got %0d required >0", b_st);
    end
`else
    if (a_st == 0) begin
      bad++; $display("FAIL rr_backpressure: a stall cycles got %0d required >0", a_st);
    end
`endif
    total++;
    if (log_q.size() != 8) begin
      bad++; $display("FAIL rr_count: got %0d writes required 8", log_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rr_order[%0d]: got %h required %h", i, (i < log_q.size()) ? log_q[i] : 19'h7ffff, exp_q[i]);
      end
    end
    total++;
    if ({pending, busy} !== 9'd0) begin
      bad++; $display("FAIL rr_drained: got pend=%h busy=%b required 00/0", pending, busy);
    end
  endtask

  task automatic test_single();
    log_q.delete();
    @(posedge clk); #1;
    a_valid = 1'b1; a_addr = 3'd3; a_data = 16'h1234;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({pending, rf_RegWrite, busy} !== {8'h08, 1'b0, 1'b1}) begin
      bad++; $display("FAIL single_queued: got pend=%h we=%b busy=%b required 08/0/1", pending, rf_RegWrite, busy);
    end
    @(negedge clk);
    total++;
    if ({rf_RegWrite, rf_RW, rf_WD, pending} !== {1'b1, 3'd3, 16'h1234, 8'h08}) begin
      bad++;
      $display("FAIL single_write: got we=%b rw=%0d wd=%h pend=%h required 1/3/1234/08", rf_RegWrite, rf_RW, rf_WD, pending);
    end
    @(negedge clk);
    total++;
    if ({rf_RegWrite, pending, busy} !== {1'b0, 8'h00, 1'b0}) begin
      bad++; $display("FAIL single_done: got we=%b pend=%h busy=%b required 0/00/0", rf_RegWrite, pending, busy);
    end
    total++;
    if ({rf_RW, rf_WD} !== {3'd3, 16'h1234}) begin
      bad++; $display("FAIL single_hold: got rw=%0d wd=%h required 3/1234", rf_RW, rf_WD);
    end
    total++;
    if (log_q.size() != 1) begin
      bad++; $display("FAIL single_pulse_len: got %0d write cycles required 1", log_q.size());
    end
  endtask

  task automatic test_zero_reg();
    log_q.delete();
    @(posedge clk); #1;
    b_valid = 1'b1; b_addr = 3'd0; b_data = 16'hFFFF;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rf_RegWrite, pending, busy} !== {1'b0, 8'h00, 1'b1}) begin
      bad++; $display("FAIL zero_queued: got we=%b pend=%h busy=%b required 0/00/1", rf_RegWrite, pending, busy);
    end
    @(negedge clk);
    total++;
    if ({rf_RegWrite, rf_RW, rf_WD, pending} !== {1'b0, 3'd0, 16'hFFFF, 8'h00}) begin
      bad++;
      $display("FAIL zero_popped: got we=%b rw=%0d wd=%h pend=%h required 0/0/ffff/00", rf_RegWrite, rf_RW, rf_WD, pending);
    end
    @(negedge clk);
    total++;
    if ({rf_RegWrite, busy, log_q.size() == 0} !== {1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL zero_done: got we=%b busy=%b writes=%0d required 0/0/0", rf_RegWrite, busy, log_q.size());
    end
  endtask

  task automatic test_flush();
    log_q.delete();
    @(posedge clk); #1;
    a_valid = 1'b1; a_addr = 3'd1; a_data = 16'h1111;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 16'h2222;
    @(posedge clk); #1;
    a_addr = 3'd3; a_data = 16'h3333;
    b_valid = 1'b0;
    @(posedge clk); #1;
    a_addr = 3'd5; a_data = 16'h5555;
    flush = 1'b1;
    @(negedge clk);
    total++;
    if ({rf_RegWrite, rf_RW, rf_WD, pending, busy, a_ready, b_ready} !== {1'b1, 3'd1, 16'h1111, 8'h0E, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL flush_inflight: got we=%b rw=%0d wd=%h pend=%h busy=%b ar=%b br=%b required 1/1/1111/0e/1/0/0",
               rf_RegWrite, rf_RW, rf_WD, pending, busy, a_ready, b_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    a_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({rf_RegWrite, pending, busy, rf_RW} !== {1'b0, 8'h00, 1'b0, 3'd1}) begin
        bad++;
        $display("FAIL flush_cleared: got we=%b pend=%h busy=%b rw=%0d required 0/00/0/1", rf_RegWrite, pending, busy, rf_RW);
      end
    end
    repeat (4) @(negedge clk);
    total++;
    if (log_q.size() != 1 || log_q[0] !== {3'd1, 16'h1111}) begin
      bad++;
      $display("FAIL flush_writes: got %0d writes first=%h required 1 write 1_1111", log_q.size(),
               (log_q.size() > 0) ? log_q[0] : 19'h7ffff);
    end
  endtask

  task automatic test_async_reset();
    log_q.delete();
    @(posedge clk); #1;
    a_valid = 1'b1; a_addr = 3'd6; a_data = 16'h6666;
    @(posedge clk); #1;
    a_addr = 3'd7; a_data = 16'h7777;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rf_RegWrite, rf_RW, rf_WD, pending} !== {1'b1, 3'd6, 16'h6666, 8'hC0}) begin
      bad++;
      $display("FAIL async_pre: got we=%b rw=%0d wd=%h pend=%h required 1/6/6666/c0", rf_RegWrite, rf_RW, rf_WD, pending);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({rf_RW, rf_WD, rf_RegWrite, rf_enable, pending, busy} !== 29'd0) begin
      bad++;
      $display("FAIL async_clear: got %h required 0", {rf_RW, rf_WD, rf_RegWrite, rf_enable, pending, busy});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (log_q.size() != 1 || busy !== 1'b0 || rf_enable !== 1'b1) begin
      bad++;
      $display("FAIL async_lost: got writes=%0d busy=%b en=%b required 1/0/1", log_q.size(), busy, rf_enable);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_reg();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back scheduler in front of the 8x16 register file's single write port. Two requesters share the port: A (ALU write-back) and B (memory/load write-back). Each has a DEPTH-entry FIFO. A round-robin arbiter drains the FIFOs one write per cycle through a registered output stage that drives RW/WD/RegWrite/rf_enable. A per-register pending vector lets issue logic stall on outstanding writes.

Parameters:
DEPTH, 2, entries per requester FIFO; power of two, >=2
DATA_W, 16, write data width
ADDR_W, 3, register address width
NREG, 8, register count (2**ADDR_W)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  reset, asynchronous, active-low
flush  input  1  synchronous clear of both FIFOs
a_valid  input  1  requester A write request
a_ready  output  1  A FIFO can accept
a_addr  input  ADDR_W  A destination register
a_data  input  DATA_W  A write data
b_valid  input  1  requester B write request
b_ready  output  1  B FIFO can accept
b_addr  input  ADDR_W  B destination register
b_data  input  DATA_W  B write data
rf_RW  output  ADDR_W  register file write address
rf_WD  output  DATA_W  register file write data
rf_RegWrite  output  1  register file write enable, one-cycle pulse per write
rf_enable  output  1  register file enable
pending  output  NREG  bit i = write to Ri queued or in output stage
busy  output  1  any FIFO non-empty or output stage valid

Behaviour:
- Reset (rst=0, async): both FIFOs empty, read/write pointers 0, rr_ptr=A, output stage invalid, rf_RW=0, rf_WD=0, rf_RegWrite=0, rf_enable=0, pending=0, busy=0. Queued writes are lost.
- rf_enable=1 from the first rising edge after reset release and held thereafter.
- Accept: x_ready = !full_x && !flush. A push happens on an edge where x_valid && x_ready. A push into a full FIFO is never allowed, even with a same-cycle pop.
- Arbitration is combinational on FIFO heads. Only one pop per cycle.
  - Both non-empty: grant rr_ptr, then rr_ptr <= other requester.
  - One non-empty: grant it, then rr_ptr <= other requester.
  - None non-empty: no grant, rr_ptr unchanged.
- Output stage: on a grant, popped entry is registered at that edge. rf_RegWrite=1 for exactly the next cycle if addr!=0. Entries with addr==0 are popped and discarded, with rf_RegWrite=0 and rf_RW/rf_WD updated.
- No grant: rf_RegWrite=0; rf_RW and rf_WD hold their values.
- Latency: push at edge k, sole entry, gives a pop at edge k+1 and rf_RegWrite high in cycle k+1..k+2. Sustained throughput is one write per cycle.
- Ordering: FIFO order is preserved within a requester. No ordering between A and B; issue logic must use pending to avoid same-register WAW across requesters.
- pending[i] = OR over valid FIFO entries and valid output stage with addr==i. pending[0] is always 0.
- flush (sync, edge-sampled): both FIFOs emptied, pushes suppressed. The output stage still completes its write. A pop on the same edge is suppressed. rr_ptr is unchanged.
- Pointer wrap: read/write pointers are ADDR bits plus an extra wrap bit. full = equal index, differing wrap bit.

Optional Feature:
Macro REGFILE_WB_FIXED_PRIO_EN.
- Defined: A has strict priority. B is granted only when A's FIFO is empty. rr_ptr is removed.
- Undefined: round-robin as above.

Test Plan:
- Reset release, idle 3 cycles -> rf_enable=1 after first edge; rf_RegWrite=0, pending=0, busy=0.
- A pushes R3=0x1234 alone -> pending[3]=1 next cycle. rf_RegWrite=1 with rf_RW=3, rf_WD=0x1234 exactly one cycle, two edges after push. pending[3]=0 after.
- A and B push continuously (A: R1..R4, B: R5..R7, R1) -> write order A,B,A,B,... starting with A. With REGFILE_WB_FIXED_PRIO_EN, all A writes precede B.
- Fill A (DEPTH=2), no drain possible due to B priority turn -> a_ready=0 when full. A third push is held off and later written with correct data; no entry lost or duplicated.
- B pushes R0=0xFFFF -> entry popped, rf_RegWrite stays 0, pending stays 0.
- Two entries queued, output stage valid, assert flush one cycle -> in-flight write completes. Queued entries are never written; busy=0 and pending=0 two cycles later. Async rst mid-stream clears all outputs immediately.
